// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, access sizes, lane count.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment: lane mask, store replication, load extension, fault flags.
// Zero latency; no state and no backpressure.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]       off,
    input  logic [2:0]       funct3,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rword,
    output logic [LANES-1:0] wmask,
    output logic [31:0]      wdata_rep,
    output logic [31:0]      rdata,
    output logic             misaligned,
    output logic             illegal
);

    size_e       size;
    logic        access;
    logic        ok;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (funct3)
            F3_B, F3_BU: size = SZ_BYTE;
            F3_H, F3_HU: size = SZ_HALF;
            F3_W:        size = SZ_WORD;
            default:     size = SZ_NONE;
        endcase
    end

    assign access = mem_read | mem_write;
    // Unsigned variants exist only for loads, so any store with funct3[2] set is reserved.
    assign illegal    = access & ((size == SZ_NONE) | (mem_write & funct3[2]));
    assign misaligned = access & (((size == SZ_HALF) & off[0]) |
                                  ((size == SZ_WORD) & (off != 2'b00)));
    assign ok = ~illegal & ~misaligned;

    always_comb begin
        wmask     = '0;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                wmask     = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wmask     = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: wmask = 4'b1111;
            default: wmask = '0;
        endcase
        if (!(mem_write && ok)) wmask = '0;
    end

    always_comb begin
        case (off)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = off[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        rdata = '0;
        if (mem_read && ok) begin
            case (size)
                SZ_BYTE: rdata = {{24{sel_byte[7] & ~funct3[2]}}, sel_byte};
                SZ_HALF: rdata = {{16{sel_half[15] & ~funct3[2]}}, sel_half};
                SZ_WORD: rdata = rword;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/riscv_data_mem.sv
// Byte-addressable RV32I data memory: combinational extended loads, byte-lane stores on the edge.
// Stores commit in one edge; reset clears the whole array in one edge and overrides any store.
module riscv_data_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [LANES-1:0] wmask;
    logic [31:0]      wdata_rep;
    logic [31:0]      al_rdata;
    logic             al_misaligned;
    logic             al_illegal;
    logic             unused_addr_hi;

    // Upper address bits alias the array.
    assign idx            = addr[IDX_W+1:2];
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    lsu_align u_align (
        .off        (addr[1:0]),
        .funct3     (funct3),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .wdata      (wdata),
        .rword      (mem_q[idx]),
        .wmask      (wmask),
        .wdata_rep  (wdata_rep),
        .rdata      (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    assign rdata      = rst ? 32'd0 : al_rdata;
    assign misaligned = ~rst & al_misaligned;
    assign illegal    = ~rst & al_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) mem_q[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
            end
        end
    end

endmodule

// File: doc/riscv_data_mem.md
# riscv_data_mem

Byte-addressable data memory with integrated load/store alignment for the single-cycle RV32I datapath. Sits directly downstream of the ALU. The ALU result is the effective address and rs2 is the store data. The block performs SB/SH/SW byte-lane writes on the clock edge and returns LB/LH/LW/LBU/LHU data combinationally, already extended, for the writeback mux. Misaligned and illegal accesses are detected and suppressed here, not in the ALU.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two.
- IDX_W, $clog2(DEPTH_WORDS): word-index width (derived).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- addr, input, 32: byte address (ALU output).
- wdata, input, 32: store data (rs2); only the low byte or halfword is used for SB/SH.
- mem_read, input, 1: load strobe for this cycle.
- mem_write, input, 1: store strobe for this cycle.
- funct3, input, 3: access size and sign (instruction bits 14:12).
- rdata, output, 32: extended load result; 0 when not loading.
- misaligned, output, 1: current access is misaligned; the access is suppressed.
- illegal, output, 1: current access uses a reserved funct3; the access is suppressed.

## Operation
- Word index = addr[IDX_W+1:2]. Bits above IDX_W+1 are ignored, so addresses alias modulo 4*DEPTH_WORDS. Byte offset = addr[1:0].
- Loads:
  - funct3 000 = LB, sign-extend selected byte.
  - funct3 001 = LH, sign-extend halfword at addr[1].
  - funct3 010 = LW, full word.
  - funct3 100 = LBU, zero-extend byte.
  - funct3 101 = LHU, zero-extend halfword.
- Stores:
  - funct3 000 = SB, one lane enabled (byte lane = addr[1:0]).
  - funct3 001 = SH, two lanes (lanes 1:0 or 3:2).
  - funct3 010 = SW, all four lanes.
  - wdata is replicated into the enabled lanes (byte into all lanes, halfword into both halves).
- Misaligned:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, asserts misaligned when mem_read or mem_write is high.
  - The store is dropped and rdata is 0.
- Illegal:
  - funct3 011, 110, or 111 with mem_read or mem_write high asserts illegal.
  - The store is dropped and rdata is 0.
  - For stores, funct3 1xx is also illegal.
- mem_read low: rdata = 0 regardless of address.
- mem_read and mem_write both high:
  - The write commits at the edge.
  - rdata shows pre-edge contents (read-before-write) and updates after the edge.
- Little-endian throughout: byte lane 0 = bits 7:0.

## Timing
- Reads are combinational, with zero latency from addr/funct3/mem_read to rdata. Required for single-cycle operation.
- Writes commit on the rising clk edge where mem_write=1, rst=0, misaligned=0, and illegal=0. Latency is one edge.
- Reset:
  - rst high at an edge clears every word to 0 in that single edge.
  - Any store presented in the same cycle is discarded (reset wins).
  - While rst=1, rdata=0, misaligned=0, illegal=0.
- Reset mid-program: memory contents are lost. There is no partial-clear state.
- No handshake: strobes are single-cycle qualifiers; holding mem_write high for N cycles writes N times (idempotent).
- Outputs after reset deassertion: rdata=0 until a load is issued; misaligned=0, illegal=0.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Access-size enum.
  - Byte-lane mask width constant (4).
- Sub-module `lsu_align`, purely combinational. It generates the lane mask, replicates store data, extracts and extends load data, and produces the misaligned/illegal flags.
- The top level holds the memory array and the write/reset process only.

## Test plan
- Reset clear: preload word 0 = 32'hDEADBEEF, assert rst for 1 edge, then LW addr 0 → rdata 32'h00000000.
- Byte loads: SW 32'h80FF7F01 @ 0x10; LB 0x13 → 32'hFFFFFF80; LBU 0x13 → 32'h00000080; LB 0x11 → 32'h0000007F.
- Sub-word stores: SW 0 @ 0x20; SB 32'hAB @ 0x22; SH 32'h1234 @ 0x20; LW 0x20 → 32'h00AB1234.
- Misaligned: SW 32'h11111111 @ 0x31 → misaligned=1, no write; LW 0x30 → previous contents unchanged. LH @ 0x33 → misaligned=1, rdata=0.
- Illegal and idle: mem_write with funct3=011 → illegal=1, memory unchanged. mem_read=0 with a valid address → rdata=0.
- Read/write collision and reset race: with mem_read=mem_write=1 and SW 32'h5 @ 0x40 (old 0), rdata=0 before the edge and 5 after. A store with rst=1 in the same cycle → the location reads 0.
